// File: rtl/frame_stats.sv
// rtl/frame_stats.sv - per-frame mean/variance of a sample stream with frame framing checks
module frame_stats #(
    parameter int DATA_WIDTH = 8,
    parameter int LOG2_N     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      valid_in,
    input  logic                      last_in,
    input  logic                      user_in,
    output logic                      ready_out,
    output logic [DATA_WIDTH-1:0]     mean_out,
    output logic [2*DATA_WIDTH-1:0]   var_out,
    output logic                      stats_valid,
    input  logic                      stats_ready,
    output logic                      frame_err
);

    localparam int N  = 1 << LOG2_N;
    localparam int SW = DATA_WIDTH + LOG2_N;
    localparam int QW = 2 * DATA_WIDTH + LOG2_N;
    localparam int CW = LOG2_N + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, CALC, OUT} state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           sum_q, sum_d;
    logic [QW-1:0]           sumsq_q, sumsq_d;
    logic [CW-1:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0]   mean_q, mean_d;
    logic [2*DATA_WIDTH-1:0] var_q, var_d;
    logic                    frame_err_q, frame_err_d;

    logic                    accept;
    logic [2*DATA_WIDTH-1:0] data_ext;
    logic [2*DATA_WIDTH-1:0] data_sq;
    logic [DATA_WIDTH-1:0]   mean_calc;
    logic [2*DATA_WIDTH-1:0] mean_ext;
    logic [2*DATA_WIDTH-1:0] mean_sq;
    logic [2*DATA_WIDTH-1:0] sumsq_div;
    logic [2*DATA_WIDTH-1:0] var_calc;

    // Only the three input-facing states take beats; CALC/OUT apply backpressure.
    assign ready_out   = (state_q == IDLE) || (state_q == ACCUM) || (state_q == DRAIN);
    assign accept      = valid_in && ready_out;
    assign stats_valid = (state_q == OUT);
    assign mean_out    = mean_q;
    assign var_out     = var_q;
    assign frame_err   = frame_err_q;

    // Squares are formed at double width so no bits are lost before accumulation.
    assign data_ext  = {{DATA_WIDTH{1'b0}}, data_in};
    assign data_sq   = data_ext * data_ext;
    assign mean_calc = DATA_WIDTH'(sum_q >> LOG2_N);
    assign mean_ext  = {{DATA_WIDTH{1'b0}}, mean_calc};
    assign mean_sq   = mean_ext * mean_ext;
    // floor(sumsq/N) >= floor(sum/N)^2 always holds, so this never wraps.
    assign sumsq_div = (2*DATA_WIDTH)'(sumsq_q >> LOG2_N);
    assign var_calc  = sumsq_div - mean_sq;

    // Next-state, accumulator and error-pulse logic.
    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        sumsq_d     = sumsq_q;
        count_d     = count_q;
        mean_d      = mean_q;
        var_d       = var_q;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && user_in) begin
                    if (last_in) begin
                        // A one-beat frame is too short: flag it and stay idle.
                        frame_err_d = 1'b1;
                    end else begin
                        sum_d   = SW'(data_in);
                        sumsq_d = QW'(data_sq);
                        count_d = CW'(1);
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (user_in) begin
                        // Unexpected frame start: abandon the partial frame.
                        frame_err_d = 1'b1;
                        if (last_in) begin
                            sum_d   = '0;
                            sumsq_d = '0;
                            count_d = '0;
                            state_d = IDLE;
                        end else begin
                            sum_d   = SW'(data_in);
                            sumsq_d = QW'(data_sq);
                            count_d = CW'(1);
                        end
                    end else if (last_in) begin
                        if (count_q == LAST_CNT) begin
                            sum_d   = sum_q + SW'(data_in);
                            sumsq_d = sumsq_q + QW'(data_sq);
                            count_d = '0;
                            state_d = CALC;
                        end else begin
                            frame_err_d = 1'b1;
                            sum_d       = '0;
                            sumsq_d     = '0;
                            count_d     = '0;
                            state_d     = IDLE;
                        end
                    end else if (count_q == LAST_CNT) begin
                        // Nth sample without last: discard until the stray last arrives.
                        frame_err_d = 1'b1;
                        sum_d       = '0;
                        sumsq_d     = '0;
                        count_d     = '0;
                        state_d     = DRAIN;
                    end else begin
                        sum_d   = sum_q + SW'(data_in);
                        sumsq_d = sumsq_q + QW'(data_sq);
                        count_d = count_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (accept && last_in) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                mean_d  = mean_calc;
                var_d   = var_calc;
                state_d = OUT;
            end
            OUT: begin
                if (stats_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            sumsq_q     <= '0;
            count_q     <= '0;
            mean_q      <= '0;
            var_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            sumsq_q     <= sumsq_d;
            count_q     <= count_d;
            mean_q      <= mean_d;
            var_q       <= var_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule
